serial_mag_comp: RTL and testbench

- Multi-bit serial magnitude comparator.
- Accepts two WIDTH-bit operands through a valid/ready handshake.
- Shifts the operands MSB-first, one bit pair per cycle, through the team's 1-bit comparator stage (lt/gt/eq with enable). Stops early at the first differing bit.
- Presents a registered one-hot lt/gt/eq result with a done pulse. Sits directly downstream of operand sources and wraps/consumes the 1-bit compare stage.

---
 rtl/serial_mag_comp_pkg.sv | 18 +
 rtl/serial_mag_comp_if.sv | 26 ++
 rtl/serial_mag_comp_comp1.sv | 18 +
 rtl/serial_mag_comp.sv | 96 +++++++++
 tb/tb_serial_mag_comp.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_mag_comp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
package serial_mag_comp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned DefaultWidth = 8;

  // Result encoding, packed as {lt, gt, eq}
  localparam logic [2:0] ResNone = 3'b000;
  localparam logic [2:0] ResLt   = 3'b100;
  localparam logic [2:0] ResGt   = 3'b010;
  localparam logic [2:0] ResEq   = 3'b001;

endpackage

// File: rtl/serial_mag_comp_if.sv
// Operand handshake and result bus of the serial magnitude comparator.
interface serial_mag_comp_if #(
  parameter int unsigned WIDTH = serial_mag_comp_pkg::DefaultWidth
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             lt;
  logic             gt;
  logic             eq;

  // Operand source side
  modport master (
    output start_valid, a_in, b_in,
    input  start_ready, busy, done, lt, gt, eq
  );

  // Comparator side
  modport slave (
    input  start_valid, a_in, b_in,
    output start_ready, busy, done, lt, gt, eq
  );
endinterface

// File: rtl/serial_mag_comp_comp1.sv
// 1-bit comparator stage: x = a<b, y = a>b, z = a==b, all gated by en.
module serial_mag_comp_comp1 (
  input  logic a,
  input  logic b,
  input  logic en,
  output logic x,
  output logic y,
  output logic z
);

  // Pure combinational bit compare
  always_comb begin
    x = en & ~a & b;
    y = en & a & ~b;
    z = en & ~(a ^ b);
  end

endmodule

// File: rtl/serial_mag_comp.sv
// Serial MSB-first magnitude comparator; stops at the first differing bit.
module serial_mag_comp
  import serial_mag_comp_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input logic              clk,
  input logic              rst_n,
  serial_mag_comp_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2:0]       res_q, res_d;  // {lt, gt, eq}
  logic             bit_lt, bit_gt, bit_eq;

  serial_mag_comp_comp1 u_comp1 (
    .a  (sh_a_q[WIDTH-1]),
    .b  (sh_b_q[WIDTH-1]),
    .en (1'b1),
    .x  (bit_lt),
    .y  (bit_gt),
    .z  (bit_eq)
  );

  // Next-state: operand capture, MSB compare, shift and count down
  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      StIdle: begin
        if (bus.start_valid) begin
          sh_a_d  = bus.a_in;
          sh_b_d  = bus.b_in;
          cnt_d   = CntW'(WIDTH - 1);
          state_d = StRun;
        end
      end
      StRun: begin
        if (bit_gt) begin
          res_d   = ResGt;
          state_d = StDone;
        end else if (bit_lt) begin
          res_d   = ResLt;
          state_d = StDone;
        end else if (bit_eq) begin
          if (cnt_q == '0) begin
            res_d   = ResEq;
            state_d = StDone;
          end else begin
            sh_a_d = {sh_a_q[WIDTH-2:0], 1'b0};
            sh_b_d = {sh_b_q[WIDTH-2:0], 1'b0};
            cnt_d  = cnt_q - CntW'(1);
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      cnt_q   <= '0;
      res_q   <= ResNone;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // Status and result outputs decoded from registered state
  always_comb begin
    bus.start_ready = (state_q == StIdle);
    bus.busy        = (state_q != StIdle);
    bus.done        = (state_q == StDone);
    bus.lt          = res_q[2];
    bus.gt          = res_q[1];
    bus.eq          = res_q[0];
  end

endmodule

// File: tb/tb_serial_mag_comp.sv
// Bench for serial_mag_comp: directed vector table, handshake and reset corner
// cases, and random back-to-back traffic on WIDTH=8 and WIDTH=3 instances.
module tb_serial_mag_comp;
  import serial_mag_comp_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  serial_mag_comp_if #(.WIDTH(8)) bus8 ();
  serial_mag_comp_if #(.WIDTH(3)) bus3 ();

  serial_mag_comp #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_mag_comp #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  typedef struct {
    logic [2:0] res;
    int         run;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] res;
    int         run;
  } vec_t;

  exp_t sb8[$];
  exp_t sb3[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: highest differing bit decides, RUN cycles = w - p (w if equal)
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int w);
    exp_t e;
    e.res = ResEq;
    e.run = w;
    for (int i = w - 1; i >= 0; i--) begin
      if (a[i] != b[i]) begin
        e.res = a[i] ? ResGt : ResLt;
        e.run = w - i;
        break;
      end
    end
    return e;
  endfunction

  // Scoreboard for the 8-bit instance
  logic acc8_pend = 1'b0;
  logic prev_done8 = 1'b0;
  int   cyc8 = 0;
  always @(posedge clk) cyc8 <= acc8_pend ? 0 : cyc8 + 1;
  always @(negedge clk) begin
    if (!rst_n) begin
      sb8.delete();
      acc8_pend  <= 1'b0;
      prev_done8 <= 1'b0;
    end else begin
      chk("ready8_vs_busy", 32'(bus8.start_ready), 32'(!bus8.busy));
      if (prev_done8) chk("ready8_after_done", 32'(bus8.start_ready), 32'(1));
      if (bus8.done) begin
        if (sb8.size() == 0) begin
          chk("done8_without_op", 32'(bus8.done), 32'(0));
        end else begin
          exp_t e;
          e = sb8.pop_front();
          chk("sb8_result", 32'({bus8.lt, bus8.gt, bus8.eq}), 32'(e.res));
          chk("sb8_latency", 32'(cyc8), 32'(e.run));
        end
      end
      if (bus8.start_valid && bus8.start_ready)
        sb8.push_back(model(32'(bus8.a_in), 32'(bus8.b_in), 8));
      acc8_pend  <= bus8.start_valid && bus8.start_ready;
      prev_done8 <= bus8.done;
    end
  end

  // Scoreboard for the 3-bit instance
  logic acc3_pend = 1'b0;
  logic prev_done3 = 1'b0;
  int   cyc3 = 0;
  always @(posedge clk) cyc3 <= acc3_pend ? 0 : cyc3 + 1;
  always @(negedge clk) begin
    if (!rst_n) begin
      sb3.delete();
      acc3_pend  <= 1'b0;
      prev_done3 <= 1'b0;
    end else begin
      chk("ready3_vs_busy", 32'(bus3.start_ready), 32'(!bus3.busy));
      if (prev_done3) chk("ready3_after_done", 32'(bus3.start_ready), 32'(1));
      if (bus3.done) begin
        if (sb3.size() == 0) begin
          chk("done3_without_op", 32'(bus3.done), 32'(0));
        end else begin
          exp_t e;
          e = sb3.pop_front();
          chk("sb3_result", 32'({bus3.lt, bus3.gt, bus3.eq}), 32'(e.res));
          chk("sb3_latency", 32'(cyc3), 32'(e.run));
        end
      end
      if (bus3.start_valid && bus3.start_ready)
        sb3.push_back(model(32'(bus3.a_in), 32'(bus3.b_in), 3));
      acc3_pend  <= bus3.start_valid && bus3.start_ready;
      prev_done3 <= bus3.done;
    end
  end

  // One 8-bit operation; checks the previous result holds until done
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] exp_res,
                     input int exp_run, input logic [2:0] prev);
    int n;
    @(posedge clk);
    #1;
    bus8.a_in        = a;
    bus8.b_in        = b;
    bus8.start_valid = 1'b1;
    n = 0;
    while (!bus8.start_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    bus8.start_valid = 1'b0;
    @(negedge clk);
    chk("busy_in_run", 32'(bus8.busy), 32'(1));
    chk("result_held", 32'({bus8.lt, bus8.gt, bus8.eq}), 32'(prev));
    n = 1;
    while (!bus8.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(bus8.done), 32'(1));
    chk("op_latency", 32'(n - 1), 32'(exp_run));
    chk("op_result", 32'({bus8.lt, bus8.gt, bus8.eq}), 32'(exp_res));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    vec_t       vecs[9];
    logic [2:0] prev;
    int         n;

    vecs[0] = '{a: 8'h5A, b: 8'h5A, res: ResEq, run: 8};
    vecs[1] = '{a: 8'h80, b: 8'h7F, res: ResGt, run: 1};
    vecs[2] = '{a: 8'h12, b: 8'h13, res: ResLt, run: 8};
    vecs[3] = '{a: 8'hF0, b: 8'h0F, res: ResGt, run: 1};
    vecs[4] = '{a: 8'h00, b: 8'hFF, res: ResLt, run: 1};
    vecs[5] = '{a: 8'hA5, b: 8'hA4, res: ResGt, run: 8};
    vecs[6] = '{a: 8'h3C, b: 8'h34, res: ResGt, run: 5};
    vecs[7] = '{a: 8'h00, b: 8'h00, res: ResEq, run: 8};
    vecs[8] = '{a: 8'h41, b: 8'h61, res: ResLt, run: 3};

    bus8.start_valid = 1'b0;
    bus8.a_in        = '0;
    bus8.b_in        = '0;
    bus3.start_valid = 1'b0;
    bus3.a_in        = '0;
    bus3.b_in        = '0;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_ready", 32'(bus8.start_ready), 32'(1));
    chk("rst_busy", 32'(bus8.busy), 32'(0));
    chk("rst_done", 32'(bus8.done), 32'(0));
    chk("rst_result", 32'({bus8.lt, bus8.gt, bus8.eq}), 32'(ResNone));
    chk("rst3_result", 32'({bus3.lt, bus3.gt, bus3.eq}), 32'(ResNone));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    prev = ResNone;
    for (int i = 0; i < 9; i++) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].run, prev);
      prev = vecs[i].res;
    end

    // start_valid held high with operands changing every cycle
    @(posedge clk);
    #1;
    bus8.start_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      bus8.a_in = 8'($urandom);
      bus8.b_in = 8'($urandom);
      @(posedge clk);
      #1;
    end
    bus8.start_valid = 1'b0;
    n = 0;
    while ((bus8.busy || sb8.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("hold_drained", 32'(sb8.size()), 32'(0));

    // Reset in the 3rd RUN cycle of 0x00 vs 0x01
    @(posedge clk);
    #1;
    bus8.a_in        = 8'h00;
    bus8.b_in        = 8'h01;
    bus8.start_valid = 1'b1;
    @(posedge clk);
    #1;
    bus8.start_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(bus8.start_ready), 32'(1));
    chk("abort_busy", 32'(bus8.busy), 32'(0));
    chk("abort_done", 32'(bus8.done), 32'(0));
    chk("abort_result", 32'({bus8.lt, bus8.gt, bus8.eq}), 32'(ResNone));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_done_in_reset", 32'(bus8.done), 32'(0));
    end
    rst_n = 1'b1;
    op8(8'hFF, 8'h00, ResGt, 1, ResNone);

    // Random back-to-back traffic on both widths
    @(posedge clk);
    #1;
    bus8.start_valid = 1'b1;
    bus3.start_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      bus8.a_in = 8'($urandom);
      bus8.b_in = ($urandom_range(0, 3) == 0) ? bus8.a_in : 8'($urandom);
      bus3.a_in = 3'($urandom);
      bus3.b_in = 3'($urandom);
      @(posedge clk);
      #1;
    end
    bus8.start_valid = 1'b0;
    bus3.start_valid = 1'b0;
    n = 0;
    while ((bus8.busy || bus3.busy || sb8.size() != 0 || sb3.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("sb8_drained", 32'(sb8.size()), 32'(0));
    chk("sb3_drained", 32'(sb3.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
